// File: rtl/cpu_step_pkg.sv
// Purpose: shared types and defaults for the single-step / run controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_step_pkg;

  // Controller state encodings, visible on the o_state port.
  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_BREAK  = 2'd3
  } state_t;

  // Clock-enable divide ratio (legal 1..255).
  localparam int DIV_DEFAULT      = 3;
  // Consecutive stable samples needed to accept a button level (legal 1..65535).
  localparam int DEBOUNCE_DEFAULT = 65535;

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Purpose: synchronize and debounce an active-low pushbutton; emit a one-cycle press pulse.
// Latency: press pulse appears 2 sync cycles + DEBOUNCE samples after btn_n goes low.
// Backpressure: none; the button is sampled every cycle.
//
// Ports:
//   i_clk     system clock
//   i_reset_n asynchronous active-low reset
//   i_btn_n   raw active-low button, asynchronous to i_clk
//   o_press   one-cycle pulse on a debounced 1->0 transition (release gives nothing)
module btn_debounce
  import cpu_step_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn_n,
  output logic o_press
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE - 1);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_level;
  logic [15:0] r_cnt;
  logic        r_press;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      // r_cnt counts consecutive samples that differ from the accepted level;
      // a sample matching the accepted level restarts the count.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        // Only the falling (press) edge produces an event.
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Purpose: run / single-step / breakpoint controller generating a CPU clock enable.
// Latency: o_cpu_ce is registered, one cycle after the divider tick.
// Backpressure: none; all inputs are sampled every cycle.
//
// Ports:
//   i_clk, i_reset_n       clock, asynchronous active-low reset
//   i_btn_n                raw active-low pushbutton
//   i_mode_run             1: press starts free-run, 0: press executes one step
//   i_instr_retired        core retire strobe, meaningful only while o_cpu_ce=1
//   i_halted               core HALT status
//   i_pc, i_bp_addr        program counter and breakpoint address
//   i_bp_valid             breakpoint enable
//   o_cpu_ce               core clock enable
//   o_state                controller state (PAUSED/RUN/STEP/BREAK)
//   o_step_count           retired instruction count, wraps at 16 bits
//
// Build option: define CPU_STEP_BREAKPOINT_EN to include the breakpoint
// comparator and armed flag; otherwise BREAK is unreachable and the pc/bp
// inputs are ignored.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int DIV      = DIV_DEFAULT,
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_btn_n,
  input  logic        i_mode_run,
  input  logic        i_instr_retired,
  input  logic        i_halted,
  input  logic [15:0] i_pc,
  input  logic [15:0] i_bp_addr,
  input  logic        i_bp_valid,
  output logic        o_cpu_ce,
  output logic [1:0]  o_state,
  output logic [15:0] o_step_count
);

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  logic [7:0]  r_div;
  logic        w_tick;
  logic        w_press;
  logic        w_bp_hit;
  state_t      r_state;
  logic        r_cpu_ce;
  logic [15:0] r_step_count;

  btn_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_btn (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_btn_n   (i_btn_n),
    .o_press   (w_press)
  );

  // Free-running divider; with DIV=1 it stays at 0 and ticks every cycle.
  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 8'd1;
    end
  end

`ifdef CPU_STEP_BREAKPOINT_EN
  // armed stays low until the first enable of a RUN episode has been issued,
  // so resuming at the breakpoint address executes that instruction.
  logic r_armed;

  assign w_bp_hit = (r_state == ST_RUN) && r_armed && i_bp_valid && w_tick &&
                    (i_pc == i_bp_addr);
`else
  logic w_unused_bp;

  assign w_bp_hit    = 1'b0;
  assign w_unused_bp = ^{i_pc, i_bp_addr, i_bp_valid};
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= ST_PAUSED;
      r_cpu_ce <= 1'b0;
`ifdef CPU_STEP_BREAKPOINT_EN
      r_armed  <= 1'b0;
`endif
    end else begin
      // A breakpoint hit swallows the enable for the tick that detected it.
      r_cpu_ce <= w_tick && ((r_state == ST_RUN) || (r_state == ST_STEP)) && !w_bp_hit;
      case (r_state)
        ST_PAUSED: begin
          if (w_press) begin
            if (i_mode_run) begin
              r_state <= ST_RUN;
`ifdef CPU_STEP_BREAKPOINT_EN
              r_armed <= 1'b0;
`endif
            end else begin
              r_state <= ST_STEP;
            end
          end
        end
        ST_RUN: begin
`ifdef CPU_STEP_BREAKPOINT_EN
          if (r_cpu_ce) begin
            r_armed <= 1'b1;
          end
`endif
          // Priority: breakpoint hit, then halt, then press.
          if (w_bp_hit) begin
            r_state <= ST_BREAK;
          end else if (i_halted || w_press) begin
            r_state <= ST_PAUSED;
          end
        end
        ST_STEP: begin
          // Presses are ignored while a step is in flight.
          if ((i_instr_retired && r_cpu_ce) || i_halted) begin
            r_state <= ST_PAUSED;
          end
        end
        ST_BREAK: begin
          if (w_press) begin
            r_state <= ST_PAUSED;
          end
        end
        default: begin
          r_state <= ST_PAUSED;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_step_count <= '0;
    end else if (i_instr_retired && r_cpu_ce) begin
      r_step_count <= r_step_count + 16'd1;
    end
  end

  assign o_cpu_ce     = r_cpu_ce;
  assign o_state      = r_state;
  assign o_step_count = r_step_count;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Purpose: directed self-checking bench for cpu_step_ctrl (DIV=3, DEBOUNCE=4),
//          plus a DIV=1 instance used to reach the step counter wrap quickly.
// Latency/backpressure: n/a.
module tb_cpu_step_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_n;
  logic        mode_run;
  logic        retired;
  logic        halted;
  logic [15:0] pc;
  logic [15:0] bp_addr;
  logic        bp_valid;
  logic        cpu_ce;
  logic [1:0]  state;
  logic [15:0] step_count;

  logic        btn1_n;
  logic        retired1;
  logic        cpu_ce1;
  logic [1:0]  state1;
  logic [15:0] step_count1;

  int nvec = 0;
  int nerr = 0;

  // Core model controls: pc advances on every enable while pc_auto is set.
  logic pc_auto;
  logic saw150;
  logic hcd_arm;
  int   hcd;

  always #5 clk = ~clk;

  cpu_step_ctrl #(.DIV(3), .DEBOUNCE(4)) u_dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_btn_n         (btn_n),
    .i_mode_run      (mode_run),
    .i_instr_retired (retired),
    .i_halted        (halted),
    .i_pc            (pc),
    .i_bp_addr       (bp_addr),
    .i_bp_valid      (bp_valid),
    .o_cpu_ce        (cpu_ce),
    .o_state         (state),
    .o_step_count    (step_count)
  );

  cpu_step_ctrl #(.DIV(1), .DEBOUNCE(4)) u_dut1 (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_btn_n         (btn1_n),
    .i_mode_run      (1'b1),
    .i_instr_retired (retired1),
    .i_halted        (1'b0),
    .i_pc            (16'h0000),
    .i_bp_addr       (16'h0000),
    .i_bp_valid      (1'b0),
    .o_cpu_ce        (cpu_ce1),
    .o_state         (state1),
    .o_step_count    (step_count1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample point is 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    halted = 1'b0;
    if (hcd > 0) begin
      hcd--;
      if (hcd == 0) halted = 1'b1;
    end
    if (pc_auto && cpu_ce) begin
      if (pc == 16'h0150) saw150 = 1'b1;
      pc = pc + 16'd1;
      // Next tick is two cycles after this enable cycle (DIV=3).
      if (hcd_arm && pc == 16'h0150) begin
        hcd     = 2;
        hcd_arm = 1'b0;
      end
    end
  endtask

  task automatic press_btn();
    btn_n = 1'b0;
    repeat (8) cyc();
    btn_n = 1'b1;
    repeat (8) cyc();
  endtask

  initial begin
    int np;
    int p1;
    int p2;
    int bad;
    int nce;
    int n;
    int guard;

    reset_n  = 1'b0;
    btn_n    = 1'b1;
    mode_run = 1'b0;
    retired  = 1'b0;
    halted   = 1'b0;
    pc       = 16'h0000;
    bp_addr  = 16'h0000;
    bp_valid = 1'b0;
    btn1_n   = 1'b1;
    retired1 = 1'b0;
    pc_auto  = 1'b0;
    saw150   = 1'b0;
    hcd_arm  = 1'b0;
    hcd      = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ce", 32'(cpu_ce), 32'd0);
    check("rst_count", 32'(step_count), 32'd0);

    // Idle with button released.
    reset_n = 1'b1;
    repeat (50) cyc();
    check("idle_state", 32'(state), 32'd0);
    check("idle_ce", 32'(cpu_ce), 32'd0);
    check("idle_count", 32'(step_count), 32'd0);

    // Single step: retire on the second enable.
    mode_run = 1'b0;
    btn_n    = 1'b0;
    np = 0; p1 = 0; p2 = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (c == 9) btn_n = 1'b1;
      retired = 1'b0;
      if (cpu_ce) begin
        np++;
        if (np == 1) p1 = c;
        if (np == 2) begin
          p2      = c;
          retired = 1'b1;
        end
      end
    end
    check("step_pulses", 32'(np), 32'd2);
    check("step_spacing", 32'(p2 - p1), 32'd3);
    check("step_state", 32'(state), 32'd0);
    check("step_count", 32'(step_count), 32'd1);

    // Three-cycle glitch must not be accepted.
    btn_n = 1'b0;
    repeat (3) cyc();
    btn_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (state != 2'd0 || cpu_ce) bad++;
    end
    check("glitch_activity", 32'(bad), 32'd0);
    check("glitch_state", 32'(state), 32'd0);

    // Free-run toward a breakpoint at 0x0150.
    mode_run = 1'b1;
    bp_valid = 1'b1;
    bp_addr  = 16'h0150;
    pc       = 16'h014E;
    pc_auto  = 1'b1;
    saw150   = 1'b0;
    press_btn();
    nce = 0;
    for (int c = 0; c < 30; c++) begin
      cyc();
      if (c >= 10 && cpu_ce) nce++;
    end
`ifdef CPU_STEP_BREAKPOINT_EN
    check("bp_state", 32'(state), 32'd3);
    check("bp_no_ce_at_hit", 32'(saw150), 32'd0);
    check("bp_pc_held", 32'(pc), 32'h0150);
    check("bp_ce_held_low", 32'(nce), 32'd0);
`else
    check("nobp_state", 32'(state), 32'd1);
    check("nobp_ce_at_addr", 32'(saw150), 32'd1);
`endif
    press_btn();
    check("bp_press_pause", 32'(state), 32'd0);

    // Resume at the breakpoint address: the instruction there must execute.
    pc     = 16'h0150;
    saw150 = 1'b0;
    press_btn();
    repeat (6) cyc();
    check("resume_ce_at_addr", 32'(saw150), 32'd1);
    check("resume_state", 32'(state), 32'd1);
    press_btn();
    check("resume_pause", 32'(state), 32'd0);

    // Halt asserted on the same tick as a breakpoint hit.
    pc      = 16'h014E;
    hcd_arm = 1'b1;
    press_btn();
    repeat (10) cyc();
`ifdef CPU_STEP_BREAKPOINT_EN
    check("bp_beats_halt", 32'(state), 32'd3);
    press_btn();
    check("bp_halt_pause", 32'(state), 32'd0);
`else
    check("halt_no_bp", 32'(state), 32'd0);
`endif
    check("halt_pulse_seen", 32'(hcd_arm), 32'd0);
    pc_auto  = 1'b0;
    bp_valid = 1'b0;

    // Step counter wrap on the DIV=1 instance.
    btn1_n = 1'b0;
    repeat (8) cyc();
    btn1_n = 1'b1;
    repeat (8) cyc();
    check("wrap_run_state", 32'(state1), 32'd1);
    retired1 = 1'b1;
    n = 0;
    guard = 0;
    while (n < 65535 && guard < 70000) begin
      if (cpu_ce1) n++;
      cyc();
      guard++;
    end
    retired1 = 1'b0;
    check("wrap_guard", 32'(n), 32'd65535);
    check("wrap_ffff", 32'(step_count1), 32'h0000FFFF);
    check("wrap_ce_high", 32'(cpu_ce1), 32'd1);
    retired1 = 1'b1;
    cyc();
    retired1 = 1'b0;
    check("wrap_zero", 32'(step_count1), 32'd0);

    // Asynchronous reset in the middle of a step.
    mode_run = 1'b0;
    press_btn();
    for (int k = 0; k < 10 && !cpu_ce; k++) cyc();
    check("pre_rst_state", 32'(state), 32'd2);
    check("pre_rst_ce", 32'(cpu_ce), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_ce", 32'(cpu_ce), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_count", 32'(step_count), 32'd0);
    check("async_rst_count1", 32'(step_count1), 32'd0);
    repeat (2) @(posedge clk);
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 3: clock-enable divide ratio; cpu_ce pulses once every DIV clk cycles; legal range 1..255.
REQ-002 SHALL have parameter DEBOUNCE, default 65535: number of consecutive stable synchronized samples needed to accept a button level; legal range 1..65535.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  system clock; reset_n  input  1  asynchronous active-low reset.
REQ-004 btn_n  input  1  raw active-low pushbutton, asynchronous to clk.
REQ-005 mode_run  input  1  1 = a press starts free-run; 0 = a press executes a single step.
REQ-006 instr_retired  input  1  core retire strobe; only meaningful in a cycle where cpu_ce=1.
REQ-007 halted  input  1  core HALT status.
REQ-008 pc  input  16  core program counter.
REQ-009 bp_addr  input  16  breakpoint address; bp_valid  input  1  breakpoint enable.
REQ-010 cpu_ce  output  1  core clock enable, registered.
REQ-011 state  output  2  current controller state.
REQ-012 step_count  output  16  count of retired instructions.

Function
REQ-013 btn_n SHALL pass through a 2-flop synchronizer.
REQ-014 Debounced level SHALL change only after DEBOUNCE consecutive synchronized samples at the new level; any differing sample SHALL restart the count.
REQ-015 A press SHALL be a single-cycle pulse on a debounced 1->0 transition; release SHALL generate no event.
REQ-016 Divider SHALL count 0..DIV-1, free-running in every state; tick=1 when the count equals DIV-1. With DIV=1, tick SHALL be 1 every cycle.
REQ-017 State encodings SHALL be PAUSED=0, RUN=1, STEP=2, BREAK=3.
REQ-018 cpu_ce SHALL be registered and equal 1 for exactly one cycle after a cycle with tick=1 in RUN or STEP, unless suppressed by REQ-024.
REQ-019 PAUSED: a press with mode_run=1 SHALL go to RUN; a press with mode_run=0 SHALL go to STEP.
REQ-020 RUN: a press or halted=1 SHALL go to PAUSED.
REQ-021 STEP: instr_retired=1 with cpu_ce=1, or halted=1, SHALL go to PAUSED. Presses SHALL be ignored.
REQ-022 BREAK: a press SHALL go to PAUSED. cpu_ce SHALL be held at 0.
REQ-023 Breakpoint hit SHALL be: state=RUN, armed=1, bp_valid=1, tick=1 and pc==bp_addr.
REQ-024 On a hit, that tick's cpu_ce pulse SHALL be suppressed and the next state SHALL be BREAK.
REQ-025 armed SHALL clear on every entry to RUN and set after the first cpu_ce pulse issued in RUN, so resuming from a breakpoint address does not re-trigger.
REQ-026 Priority for simultaneous events SHALL be: breakpoint hit > halted > press.
REQ-027 step_count SHALL increment on each instr_retired=1 with cpu_ce=1, in any state, and SHALL wrap from FFFF to 0000.

Reset
REQ-028 Reset SHALL be asynchronous; all state SHALL return to reset values immediately on reset_n=0, including mid-step or mid-debounce.
REQ-029 Reset values SHALL be: state=PAUSED, cpu_ce=0, step_count=0, divider=0, debounce count=0, synchronizer flops=1, debounced level=1, armed=0.
REQ-030 No press SHALL be generated in the first DEBOUNCE cycles after reset release.

Configuration
REQ-031 The macro CPU_STEP_BREAKPOINT_EN SHALL control breakpoint support.
REQ-032 When CPU_STEP_BREAKPOINT_EN is defined, breakpoint logic SHALL behave as in REQ-023 to REQ-025.
REQ-033 When CPU_STEP_BREAKPOINT_EN is undefined, the comparator and armed flag SHALL be omitted and BREAK SHALL be unreachable. pc, bp_addr and bp_valid ports SHALL remain and be ignored.

Structure
REQ-034 A shared package SHALL hold the state encodings and the default DIV and DEBOUNCE constants.
REQ-035 The synchronizer and debouncer SHALL be one sub-module, btn_debounce, that outputs the press pulse.

Verification (DIV=3, DEBOUNCE=4)
REQ-036 Reset, then btn_n held 1 for 50 cycles -> state=0, cpu_ce=0, step_count=0.
REQ-037 mode_run=0; btn_n low for 10 cycles; instr_retired on the 2nd cpu_ce -> exactly 2 cpu_ce pulses 3 cycles apart, state returns to 0, step_count=1.
REQ-038 btn_n glitch low for 3 cycles -> no press, state stays 0.
REQ-039 mode_run=1, press, bp_valid=1, bp_addr=0x0150, pc reaches 0x0150 -> state=3 and no cpu_ce on that tick. A press then goes to state 0. A press with mode_run=1 resumes with cpu_ce issued while pc=0x0150.
REQ-040 RUN with halted=1 asserted on the same tick as a bp hit -> state=3. With the macro undefined -> state=0.
REQ-041 step_count preloaded by running to FFFF, then one more retire -> step_count=0000. reset_n pulsed low mid-STEP -> cpu_ce=0 in the same cycle.
